// File: rtl/bus_ic_pkg.sv
// Shared types and default address map for the round-robin bus interconnect.
package bus_ic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    // Index 2..0: S2 is a 256-byte window, S0/S1 are 64 KiB windows.
    localparam logic [2:0][31:0] DEF_SLAVE_BASE = {32'h4000_0000, 32'h1000_0000, 32'h2000_0000};
    localparam logic [2:0][31:0] DEF_SLAVE_MASK = {32'hFFFF_FF00, 32'hFFFF_0000, 32'hFFFF_0000};

    // Index width that stays at least one bit for single-entry arrays.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
    import bus_ic_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    always_comb begin
        int   c;
        logic found;
        c     = 0;
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr) + k;
            if (c >= N) c = c - N;
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = IW'(c);
            end
        end
    end

endmodule

// File: rtl/bus_interconnect_rr.sv
// N-master / M-slave single-outstanding bus with round-robin arbitration,
// mask/base address decode and a per-transaction BUSY timeout.
module bus_interconnect_rr
    import bus_ic_pkg::*;
#(
    parameter int                        N_MASTERS  = 2,
    parameter int                        N_SLAVES   = 3,
    parameter logic [N_SLAVES-1:0][31:0] SLAVE_BASE = DEF_SLAVE_BASE,
    parameter logic [N_SLAVES-1:0][31:0] SLAVE_MASK = DEF_SLAVE_MASK,
    parameter int                        TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_MASTERS-1:0]          m_req,
    input  logic [N_MASTERS-1:0][31:0]    m_addr,
    input  logic [N_MASTERS-1:0]          m_we,
    input  logic [N_MASTERS-1:0][3:0]     m_be,
    input  logic [N_MASTERS-1:0][31:0]    m_wdata,
    output logic [N_MASTERS-1:0]          m_ack,
    output logic [N_MASTERS-1:0]          m_err,
    output logic [31:0]                   m_rdata,
    output logic [N_SLAVES-1:0]           s_req,
    output logic [31:0]                   s_addr,
    output logic                          s_we,
    output logic [3:0]                    s_be,
    output logic [31:0]                   s_wdata,
    input  logic [N_SLAVES-1:0][31:0]     s_rdata,
    input  logic [N_SLAVES-1:0]           s_ack
);

    localparam int MW = idx_w(N_MASTERS);
    localparam int SW = idx_w(N_SLAVES);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [MW-1:0] LAST_MST = MW'(N_MASTERS - 1);

    state_e          state_q, state_d;
    logic [MW-1:0]   rr_q, rr_d, gnt_q, gnt_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     addr_q, addr_d, wdata_q, wdata_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;

    logic [N_MASTERS-1:0] arb_grant;
    logic [MW-1:0]        arb_idx;
    logic [31:0]          req_addr, req_wdata;
    logic                 req_we;
    logic [3:0]           req_be;
    logic                 dec_hit;
    logic [SW-1:0]        dec_idx;
    logic [MW-1:0]        rr_next;

    rr_arbiter #(.N(N_MASTERS)) u_arb (
        .req   (m_req),
        .ptr   (rr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    always_comb begin
        req_addr  = '0;
        req_we    = 1'b0;
        req_be    = '0;
        req_wdata = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (arb_grant[i]) begin
                req_addr  = m_addr[i];
                req_we    = m_we[i];
                req_be    = m_be[i];
                req_wdata = m_wdata[i];
            end
        end
    end

    // Scanning downward lets the lowest matching slave overwrite higher ones.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((req_addr & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
                dec_hit = 1'b1;
                dec_idx = SW'(i);
            end
        end
    end

    assign rr_next = (gnt_q == LAST_MST) ? '0 : gnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|m_req) begin
                    gnt_d   = arb_idx;
                    sel_d   = dec_idx;
                    cnt_d   = '0;
                    addr_d  = req_addr;
                    we_d    = req_we;
                    be_d    = req_be;
                    wdata_d = req_wdata;
                    state_d = dec_hit ? ST_BUSY : ST_ERR;
                end
            end
            ST_BUSY: begin
                // An ack on the last allowed cycle still completes normally.
                if (s_ack[sel_q]) begin
                    state_d = ST_IDLE;
                    rr_d    = rr_next;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
                rr_d    = rr_next;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_ack   = '0;
        m_err   = '0;
        m_rdata = '0;
        s_req   = '0;
        s_addr  = '0;
        s_we    = 1'b0;
        s_be    = '0;
        s_wdata = '0;
        unique case (state_q)
            ST_BUSY: begin
                s_req[sel_q] = 1'b1;
                s_addr       = addr_q;
                s_we         = we_q;
                s_be         = be_q;
                s_wdata      = wdata_q;
                if (s_ack[sel_q]) begin
                    m_ack[gnt_q] = 1'b1;
                    m_rdata      = s_rdata[sel_q];
                end
            end
            ST_ERR: begin
                m_ack[gnt_q] = 1'b1;
                m_err[gnt_q] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_interconnect_rr.sv
// Directed bench: table of single-master transactions plus hand sequences
// for round-robin fairness and reset in the middle of a transaction.
module tb_bus_interconnect_rr;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       m_req;
    logic [1:0][31:0] m_addr;
    logic [1:0]       m_we;
    logic [1:0][3:0]  m_be;
    logic [1:0][31:0] m_wdata;
    logic [1:0]       m_ack, m_err;
    logic [31:0]      m_rdata;
    logic [2:0]       s_req;
    logic [31:0]      s_addr;
    logic             s_we;
    logic [3:0]       s_be;
    logic [31:0]      s_wdata;
    logic [2:0][31:0] s_rdata;
    logic [2:0]       s_ack;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_interconnect_rr #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_req   (m_req),
        .m_addr  (m_addr),
        .m_we    (m_we),
        .m_be    (m_be),
        .m_wdata (m_wdata),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .m_rdata (m_rdata),
        .s_req   (s_req),
        .s_addr  (s_addr),
        .s_we    (s_we),
        .s_be    (s_be),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_ack   (s_ack)
    );

    // lat: busy cycle on which the slave acks (0 = never); spur: slave that
    // acks spuriously while waiting (-1 = none); exp_slv -1 means unmapped.
    typedef struct {
        int          m;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        int          spur;
        int          exp_slv;
        logic        exp_err;
        int          exp_sreq;
        int          exp_lat;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".m_ack"},   {30'd0, m_ack}, 32'd0);
        chk({tag, ".m_err"},   {30'd0, m_err}, 32'd0);
        chk({tag, ".m_rdata"}, m_rdata, 32'd0);
        chk({tag, ".s_req"},   {29'd0, s_req}, 32'd0);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int          samples, busy, lat;
        logic        acked, stray, pay_bad;
        logic [1:0]  ack_v, err_v;
        logic [2:0]  exp_mask;
        logic [31:0] rd;
        string       tag;
        tag      = $sformatf("vec%0d", id);
        samples  = 0; busy = 0; lat = 0;
        acked    = 1'b0; stray = 1'b0; pay_bad = 1'b0;
        ack_v    = '0; err_v = '0; rd = '0;
        exp_mask = (v.exp_slv >= 0) ? (3'b001 << v.exp_slv) : 3'b000;
        @(posedge clk); #1;
        m_req[v.m]   = 1'b1;
        m_addr[v.m]  = v.addr;
        m_we[v.m]    = v.we;
        m_be[v.m]    = v.be;
        m_wdata[v.m] = v.wdata;
        while (!acked && samples < 20) begin
            @(negedge clk);
            samples++;
            s_ack   = '0;
            s_rdata = '0;
            if ((s_req & ~exp_mask) != 3'b000) stray = 1'b1;
            if (v.exp_slv >= 0 && s_req[v.exp_slv]) begin
                busy++;
                if (s_addr !== v.addr || s_we !== v.we || s_be !== v.be || s_wdata !== v.wdata)
                    pay_bad = 1'b1;
                if (busy == v.lat) begin
                    s_ack[v.exp_slv]   = 1'b1;
                    s_rdata[v.exp_slv] = v.rdata;
                end else if (v.spur >= 0) begin
                    s_ack[v.spur]   = 1'b1;
                    s_rdata[v.spur] = 32'hBAD0_0000;
                end
            end
            #1;
            if (m_ack != 2'b00 || m_err != 2'b00) begin
                acked = 1'b1;
                lat   = samples;
                ack_v = m_ack;
                err_v = m_err;
                rd    = m_rdata;
            end
        end
        @(posedge clk); #1;
        m_req[v.m] = 1'b0;
        s_ack      = '0;
        s_rdata    = '0;
        chk({tag, ".acked"},   {31'd0, acked}, 32'd1);
        chk({tag, ".latency"}, lat, v.exp_lat);
        chk({tag, ".ack_vec"}, {30'd0, ack_v}, 32'd1 << v.m);
        chk({tag, ".err_vec"}, {30'd0, err_v}, v.exp_err ? (32'd1 << v.m) : 32'd0);
        chk({tag, ".rdata"},   rd, v.exp_rdata);
        chk({tag, ".sreq_cycles"}, busy, v.exp_sreq);
        chk({tag, ".stray_sreq"},  {31'd0, stray}, 32'd0);
        chk({tag, ".payload"},     {31'd0, pay_bad}, 32'd0);
        @(negedge clk);
        chk_quiet({tag, ".after"});
    endtask

    task automatic rr_round(input int rep);
        logic [1:0] a;
        int         n, cyc;
        logic [1:0] got[2];
        n = 0; cyc = 0;
        got[0] = '0; got[1] = '0;
        @(posedge clk); #1;
        m_req     = 2'b11;
        m_addr[0] = 32'h2000_0000;
        m_addr[1] = 32'h1000_0000;
        m_we      = 2'b00;
        while (n < 2 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            s_ack      = s_req;
            s_rdata[0] = 32'hA0A0_0000;
            s_rdata[1] = 32'hA1A1_0001;
            #1;
            a = m_ack;
            if (a != 2'b00) begin
                got[n] = a;
                n++;
            end
            @(posedge clk); #1;
            m_req = m_req & ~a;
            s_ack = '0;
        end
        m_req = 2'b00;
        chk($sformatf("rr%0d.first", rep),  {30'd0, got[0]}, 32'd1);
        chk($sformatf("rr%0d.second", rep), {30'd0, got[1]}, 32'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        m_req   = '0;
        m_addr  = '0;
        m_we    = '0;
        m_be    = '0;
        m_wdata = '0;
        s_rdata = '0;
        s_ack   = '0;

        //                m  addr           we    be     wdata          lat rdata          spur slv err   sreq lat  exp_rdata
        vecs[0] = '{0, 32'h2000_0010, 1'b0, 4'hF, 32'h0,         3, 32'hDEAD_BEEF, -1,  0, 1'b0, 3, 4, 32'hDEAD_BEEF};
        vecs[1] = '{1, 32'h1000_0ABC, 1'b1, 4'h3, 32'h1122_3344, 1, 32'h0BAD_F00D, -1,  1, 1'b0, 1, 2, 32'h0BAD_F00D};
        vecs[2] = '{1, 32'h8000_0000, 1'b1, 4'hF, 32'h5555_AAAA, 0, 32'h0,         -1, -1, 1'b1, 0, 2, 32'h0};
        vecs[3] = '{0, 32'h4000_0004, 1'b1, 4'hF, 32'h0000_0004, 0, 32'h0,         -1,  2, 1'b1, 4, 6, 32'h0};
        vecs[4] = '{0, 32'h2000_0020, 1'b0, 4'hF, 32'h0,         3, 32'h1357_9BDF,  1,  0, 1'b0, 3, 4, 32'h1357_9BDF};
        vecs[5] = '{1, 32'h4000_00FC, 1'b0, 4'h1, 32'h0,         2, 32'hCAFE_0002, -1,  2, 1'b0, 2, 3, 32'hCAFE_0002};
        vecs[6] = '{1, 32'h4000_0100, 1'b0, 4'hF, 32'h0,         0, 32'h0,         -1, -1, 1'b1, 0, 2, 32'h0};
        vecs[7] = '{0, 32'h2000_FFFF, 1'b1, 4'hC, 32'hFEED_0007, 4, 32'h0000_0001, -1,  0, 1'b0, 4, 5, 32'h0000_0001};
        vecs[8] = '{0, 32'h1FFF_FFFF, 1'b0, 4'hF, 32'h0,         0, 32'h0,         -1, -1, 1'b1, 0, 2, 32'h0};

        // Outputs quiet under reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        chk("reset.s_addr", s_addr, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Simultaneous requesters alternate, starting from M0 after reset.
        rr_round(0);
        rr_round(1);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // vecs[8] was M0, so M1 now has priority; reset mid-BUSY returns it to M0.
        @(posedge clk); #1;
        m_req     = 2'b11;
        m_addr[0] = 32'h2000_0100;
        m_addr[1] = 32'h4000_0008;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid.m1_granted", {29'd0, s_req}, 32'h4);
        chk("rst_mid.m1_addr", s_addr, 32'h4000_0008);
        rst_n = 1'b0;
        @(negedge clk);
        chk_quiet("rst_mid.reset");
        chk("rst_mid.s_addr", s_addr, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid.m0_regrant", {29'd0, s_req}, 32'h1);
        chk("rst_mid.m0_addr", s_addr, 32'h2000_0100);
        m_req = 2'b00;
        repeat (8) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
